// File: rtl/bp_me_cce_inst_fetch.sv
// CCE microcode instruction fetch unit.
// Holds the microcode instruction RAM. While the CCE is in uncached mode the
// RAM is loaded and read back through a config port. In normal mode the unit
// streams (fetch_pc_o, inst_o) to the decoder, honouring stalls and
// zero-bubble branch redirects.
module bp_me_cce_inst_fetch #(
  parameter int cce_pc_width_p   = 8,
  parameter int cce_inst_width_p = 48
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        mode_i,
  input  logic [cce_pc_width_p-1:0]   start_pc_i,

  input  logic                        cfg_w_v_i,
  input  logic                        cfg_r_v_i,
  input  logic [cce_pc_width_p-1:0]   cfg_addr_i,
  input  logic [cce_inst_width_p-1:0] cfg_data_i,
  output logic                        cfg_ready_o,
  output logic                        cfg_data_v_o,
  output logic [cce_inst_width_p-1:0] cfg_data_o,

  input  logic                        stall_i,
  input  logic                        branch_v_i,
  input  logic [cce_pc_width_p-1:0]   branch_target_i,

  output logic [cce_pc_width_p-1:0]   fetch_pc_o,
  output logic                        inst_v_o,
  output logic [cce_inst_width_p-1:0] inst_o
);

  localparam int ram_depth_lp = 2 ** cce_pc_width_p;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [cce_pc_width_p-1:0] pc_one_lp = {{(cce_pc_width_p-1){1'b0}}, 1'b1};

  // Sequential PC advance; the natural overflow of the PC width gives the
  // wrap from the last RAM entry back to entry 0.
  function automatic logic [cce_pc_width_p-1:0] pc_inc(
    input logic [cce_pc_width_p-1:0] pc
  );
    return pc + pc_one_lp;
  endfunction

  logic [1:0]                  state_r;
  logic [1:0]                  state_n;

  // Stage p0: request side of the single RAM port.
  logic [cce_pc_width_p-1:0]   next_pc_p0;
  logic [cce_pc_width_p-1:0]   ram_addr_p0;
  logic                        ram_we_p0;
  logic                        ram_rd_fetch_p0;
  logic                        ram_rd_cfg_p0;
  logic [cce_inst_width_p-1:0] ram_rdata_p0;

  // Stage p1: registered read results driven to the outputs.
  logic [cce_pc_width_p-1:0]   fetch_pc_p1;
  logic [cce_inst_width_p-1:0] inst_p1;
  logic                        cfg_vld_p1;
  logic [cce_inst_width_p-1:0] cfg_data_p1;

  logic [cce_inst_width_p-1:0] mem [ram_depth_lp];

  // Next fetch PC in RUN: stall beats branch, branch beats sequential.
  always_comb begin
    next_pc_p0 = pc_inc(fetch_pc_p1);
    if (stall_i) begin
      next_pc_p0 = fetch_pc_p1;
    end else if (branch_v_i) begin
      next_pc_p0 = branch_target_i;
    end
  end

  // FSM next state and ownership of the RAM address/enable for this cycle.
  always_comb begin
    state_n         = state_r;
    ram_addr_p0     = cfg_addr_i;
    ram_we_p0       = 1'b0;
    ram_rd_fetch_p0 = 1'b0;
    ram_rd_cfg_p0   = 1'b0;
    case (state_r)
      IDLE: begin
        // A write and a read in the same cycle: the write takes the port.
        ram_addr_p0   = cfg_addr_i;
        ram_we_p0     = cfg_w_v_i;
        ram_rd_cfg_p0 = cfg_r_v_i & ~cfg_w_v_i;
        // Any pending config request is served before leaving IDLE.
        if (mode_i && !cfg_w_v_i && !cfg_r_v_i) begin
          state_n = PRIME;
        end
      end
      PRIME: begin
        ram_addr_p0     = start_pc_i;
        ram_rd_fetch_p0 = 1'b1;
        state_n         = RUN;
      end
      RUN: begin
        // While stalled nothing is read, so the outputs stay bit-stable;
        // a mode exit also waits for the stall to clear.
        if (!stall_i) begin
          if (mode_i) begin
            ram_addr_p0     = next_pc_p0;
            ram_rd_fetch_p0 = 1'b1;
          end else begin
            state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (ram_we_p0) begin
      mem[ram_addr_p0] <= cfg_data_i;
    end
  end

  assign ram_rdata_p0 = mem[ram_addr_p0];

  // ---- p0 -> p1 ----
  // Fetch result register: PC and instruction captured together.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fetch_pc_p1 <= '0;
      inst_p1     <= '0;
    end else if (ram_rd_fetch_p0) begin
      fetch_pc_p1 <= ram_addr_p0;
      inst_p1     <= ram_rdata_p0;
    end
  end

  // Config readback register: valid pulses for one cycle per accepted read.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cfg_vld_p1  <= 1'b0;
      cfg_data_p1 <= '0;
    end else begin
      cfg_vld_p1 <= ram_rd_cfg_p0;
      if (ram_rd_cfg_p0) begin
        cfg_data_p1 <= ram_rdata_p0;
      end
    end
  end

  assign cfg_ready_o  = (state_r == IDLE);
  assign inst_v_o     = (state_r == RUN);
  assign fetch_pc_o   = fetch_pc_p1;
  assign inst_o       = inst_p1;
  assign cfg_data_v_o = cfg_vld_p1;
  assign cfg_data_o   = cfg_data_p1;

endmodule

// File: doc/bp_me_cce_inst_fetch.md
Name: bp_me_cce_inst_fetch

Overview:
Produces the CCE microcode instruction stream: fetch PC, instruction-valid and instruction bits, which are consumed by the CCE decoder and the instruction tracer.
- Holds the instruction RAM, which software loads through a config port while the CCE is in uncached mode.
- In normal mode, fetches sequentially from a start PC.
- Honours decoder stalls and branch redirects with zero-bubble redirect.

Parameters:
cce_pc_width_p, 8, fetch PC width; RAM depth = 2**cce_pc_width_p
cce_inst_width_p, 48, instruction width in bits

Ports:
clk_i  input  1  clock; all state updates on rising edge
reset_n_i  input  1  asynchronous, active-low reset
mode_i  input  1  0 = uncached/load mode, 1 = normal fetch mode
start_pc_i  input  cce_pc_width_p  first PC fetched when entering normal mode
cfg_w_v_i  input  1  config write request
cfg_r_v_i  input  1  config read request
cfg_addr_i  input  cce_pc_width_p  config RAM address
cfg_data_i  input  cce_inst_width_p  config write data
cfg_ready_o  output  1  config port accepting requests
cfg_data_v_o  output  1  config read data valid
cfg_data_o  output  cce_inst_width_p  config read data
stall_i  input  1  decoder cannot accept; hold current instruction
branch_v_i  input  1  redirect fetch to branch_target_i
branch_target_i  input  cce_pc_width_p  redirect PC
fetch_pc_o  output  cce_pc_width_p  PC of inst_o
inst_v_o  output  1  inst_o valid
inst_o  output  cce_inst_width_p  instruction at fetch_pc_o

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE.
  - Reset values: inst_v_o=0, fetch_pc_o=0, inst_o=0, cfg_data_v_o=0, cfg_data_o=0, cfg_ready_o=1.
  - RAM contents are not reset.
- RAM: single-port, synchronous read, 1-cycle read latency. Exactly one access per cycle. The address mux is owned by the FSM.
- FSM states: IDLE, PRIME, RUN, DRAIN.
- IDLE:
  - cfg_ready_o=1.
  - cfg_w_v_i writes cfg_data_i to cfg_addr_i.
  - cfg_r_v_i reads cfg_addr_i. Next cycle cfg_data_v_o=1 and cfg_data_o=RAM[addr], held for exactly one cycle.
  - If cfg_w_v_i and cfg_r_v_i are both asserted, the write wins and the read is dropped.
  - If mode_i=1 and no config request is present this cycle, go to PRIME. A config request present in the same cycle is served and the transition is delayed one cycle.
- PRIME:
  - cfg_ready_o=0. RAM read at start_pc_i; start_pc_i is sampled here.
  - Next cycle: RUN, with inst_v_o=1, fetch_pc_o=start_pc_i, inst_o=RAM[start_pc_i].
- RUN: inst_v_o=1 and cfg_ready_o=0. Next read address (PC registered as next fetch_pc_o) is chosen by:
  - stall_i=1: next = fetch_pc_o; outputs hold bit-stable. stall_i has priority over branch_v_i, so a branch during a stall is ignored.
  - branch_v_i=1 (no stall): next = branch_target_i. No bubble; the target instruction appears next cycle.
  - otherwise: next = fetch_pc_o+1, modulo 2**cce_pc_width_p (wraps from max to 0).
- mode_i=0 while in RUN:
  - If stall_i=1, remain in RUN and hold outputs until stall_i=0.
  - Otherwise go to DRAIN; inst_v_o=0 from the next cycle.
- DRAIN: one cycle, inst_v_o=0, cfg_ready_o=0, then IDLE. This guarantees no config access overlaps the final fetch read.
- Config requests while cfg_ready_o=0 are ignored: no write, no cfg_data_v_o.
- Reset asserted mid-RUN: outputs immediately (asynchronously) take reset values. The RAM is unchanged, and the following fetch restarts from PRIME.
- Invariant: fetch_pc_o and inst_o change only on a cycle where inst_v_o=1 and stall_i=0 in the previous cycle, or on a state change.

Test Plan:
- Load and readback:
  - Stimulus: in IDLE, write RAM[0..3]=0x10,0x11,0x12,0x13; then read addr 2.
  - Response: cfg_data_v_o=1 for one cycle with cfg_data_o=0x12; cfg_ready_o=1 throughout.
- Boot and sequential fetch:
  - Stimulus: start_pc_i=1, mode_i=1.
  - Response: two cycles after the mode change, inst_v_o=1 with (pc,inst) = (1,0x11), (2,0x12), (3,0x13) on consecutive cycles.
- Stall:
  - Stimulus: assert stall_i for 3 cycles while at pc=2.
  - Response: pc=2, inst=0x12 held for 3 extra cycles; pc=3 appears the cycle after stall_i drops.
- Branch and wrap-around:
  - Stimulus 1: branch_v_i with target=0 at pc=3.
  - Response 1: next cycle (0,0x10), no bubble.
  - Stimulus 2: run from pc=255 (cce_pc_width_p=8).
  - Response 2: next pc=0.
- Branch plus stall:
  - Stimulus: stall_i and branch_v_i together at pc=1.
  - Response: pc=1 held; the branch is ignored.
- Mode exit and reset:
  - Stimulus 1: mode_i=0 in RUN.
  - Response 1: inst_v_o=0 next cycle; cfg_ready_o=1 two cycles later; config writes during the DRAIN cycle are ignored.
  - Stimulus 2: assert reset_n_i=0 mid-RUN.
  - Response 2: inst_v_o=0 immediately, and RAM contents are still readable afterward.
